// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART transmit path.
package uart_pkg;
    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

    function automatic int baud_div(input int clock_rate, input int baud_rate);
        return clock_rate / baud_rate;
    endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: first-word-fall-through byte FIFO, power-of-2 depth, async active-high reset.
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic [7:0]             i_data,
    input  logic                   i_pop,
    output logic [7:0]             o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_count = r_count;
    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign o_empty = r_count == '0;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd];

    always_ff @(posedge clk)
        if (w_push) r_mem[r_wr] <= i_data;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            r_wr    <= r_wr + AW'(w_push);
            r_rd    <= r_rd + AW'(w_pop);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: FIFO-fed 8N1 UART transmitter, LSB first, line idles high.
// Define UART_TX_PARITY_EN to insert a parity bit (even, or odd when PARITY_ODD=1).
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE = 20000000,
    parameter int BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [7:0]                  in,
    input  logic                        valid,
    output logic                        ready,
    output logic                        out,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int DIV = baud_div(CLOCK_RATE, BAUD_RATE);
    localparam int CW  = DIV > 1 ? $clog2(DIV) : 1;

    if (STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1 || FIFO_DEPTH < 2 ||
        FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || DIV < 2) begin : g_bad_param
        $error("uart_transmitter: unsupported parameter combination");
    end

    tx_state_t     r_state;
    logic [CW-1:0] r_timer;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;
    logic          r_out;
    logic [7:0]    w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_tick;

    assign ready  = !w_full;
    assign w_push = valid && !w_full;
    assign w_pop  = (r_state == IDLE) && enable && !w_empty;
    assign w_tick = r_timer == '0;
    assign out    = r_out;
    assign busy   = (r_state != IDLE) || (fifo_count != '0);

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (in),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

`ifdef UART_TX_PARITY_EN
    logic r_par;

    always_ff @(posedge clk or posedge reset)
        if (reset) r_par <= 1'b0;
        else if (w_pop) r_par <= (^w_head) ^ (PARITY_ODD != 0);
`endif

    // The timer sits at DIV-1 in IDLE so every bit, including the first, lasts DIV clocks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_out   <= 1'b1;
        end else begin
            r_timer <= (r_state == IDLE || w_tick) ? CW'(DIV - 1) : r_timer - CW'(1);
            case (r_state)
                IDLE: if (w_pop) begin
                    r_state <= START;
                    r_shift <= w_head;
                    r_out   <= 1'b0;
                end
                START: if (w_tick) begin
                    r_state <= DATA;
                    r_idx   <= '0;
                    r_out   <= r_shift[0];
                end
                DATA: if (w_tick) begin
                    r_shift <= r_shift >> 1;
                    if (r_idx == 3'(DATA_BITS - 1)) begin
                        r_idx <= '0;
`ifdef UART_TX_PARITY_EN
                        r_state <= PARITY;
                        r_out   <= r_par;
`else
                        r_state <= STOP;
                        r_out   <= 1'b1;
`endif
                    end else begin
                        r_idx <= r_idx + 3'd1;
                        r_out <= r_shift[1];
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: if (w_tick) begin
                    r_state <= STOP;
                    r_out   <= 1'b1;
                end
`endif
                STOP: if (w_tick) begin
                    if (r_idx == 3'(STOP_BITS - 1)) r_state <= IDLE;
                    else r_idx <= r_idx + 3'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: randomized checks of uart_transmitter against a bit-list frame model.
module tb_uart_transmitter;
    localparam int CLK_HZ = 100;
    localparam int BAUD   = 6;
    localparam int DEPTH  = 4;
    localparam int NSTOP  = 2;
    localparam int PODD   = 1;
    localparam int DIV    = CLK_HZ / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam int NPAR = 1;
`else
    localparam int NPAR = 0;
`endif
    localparam int FRAME = (1 + 8 + NPAR + NSTOP) * DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] in = 8'h00;
    logic       ready;
    logic       out;
    logic       busy;
    logic [2:0] fifo_count;

    int checks = 0;
    int errors = 0;

    uart_transmitter #(
        .CLOCK_RATE (CLK_HZ),
        .BAUD_RATE  (BAUD),
        .FIFO_DEPTH (DEPTH),
        .STOP_BITS  (NSTOP),
        .PARITY_ODD (PODD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .in         (in),
        .valid      (valid),
        .ready      (ready),
        .out        (out),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Reference: queued bytes plus the bit list of the frame on the line, each bit DIV clocks.
    logic [7:0] m_q[$];
    bit         m_active = 0;
    int         m_t = 0;
    logic       m_bits[12];

    function automatic logic m_line();
        return m_active ? m_bits[m_t / DIV] : 1'b1;
    endfunction

    function automatic logic [5:0] m_vec();
        return {m_line(), m_q.size() != DEPTH, m_active || m_q.size() != 0, 3'(m_q.size())};
    endfunction

    task automatic load(input logic [7:0] b);
        m_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) m_bits[1 + i] = b[i];
        if (NPAR != 0) m_bits[9] = (^b) ^ (PODD != 0);
        for (int k = 0; k < NSTOP; k++) m_bits[9 + NPAR + k] = 1'b1;
        m_active = 1;
        m_t = 0;
    endtask

    task automatic tick();
        bit pop;
        bit push;
        @(posedge clk);
        if (reset) begin
            m_q.delete();
            m_active = 0;
            m_t = 0;
        end else begin
            pop  = !m_active && enable && m_q.size() != 0;
            push = valid && m_q.size() != DEPTH;
            if (m_active) begin
                m_t++;
                if (m_t == FRAME) m_active = 0;
            end
            if (pop) load(m_q.pop_front());
            if (push) m_q.push_back(in);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        valid = 1'b0;
        enable = 1'b0;
        tick();
        tick();
        checks++;
        if ({out, ready, busy, fifo_count} !== {1'b1, 1'b1, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL reset_state got %b exp %b", {out, ready, busy, fifo_count}, 6'b110000);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single(input logic [7:0] b);
        int n;
        enable = 1'b1;
        in = b;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        tick();
        n = 1;
        checks++;
        if (out !== 1'b0) begin
            errors++;
            $display("FAIL start_latency byte %h got out=%b exp 0", b, out);
        end
        while (busy === 1'b1 && n < FRAME + 10) begin
            checks++;
            if ({out, ready, busy, fifo_count} !== m_vec()) begin
                errors++;
                $display("FAIL single_line t=%0t got %b exp %b", $time, {out, ready, busy, fifo_count}, m_vec());
            end
            tick();
            n++;
        end
        checks++;
        if (n != FRAME + 1) begin
            errors++;
            $display("FAIL frame_length byte %h got %0d exp %0d", b, n - 1, FRAME);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b[6];
        int idx;
        int n;
        bit r;
        bit full_seen;
        foreach (b[i]) b[i] = 8'($urandom);
        enable = 1'b1;
        idx = 0;
        n = 0;
        full_seen = 0;
        valid = 1'b1;
        in = b[0];
        while ((idx < 6 || busy === 1'b1) && n < 6 * (FRAME + 2) + 100) begin
            r = ready;
            tick();
            n++;
            if (r) idx++;
            valid = idx < 6;
            if (idx < 6) in = b[idx];
            if (ready === 1'b0) full_seen = 1;
            checks++;
            if ({out, ready, busy, fifo_count} !== m_vec()) begin
                errors++;
                $display("FAIL b2b_line t=%0t got %b exp %b", $time, {out, ready, busy, fifo_count}, m_vec());
            end
        end
        checks++;
        if (idx < 6 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_timeout accepted %0d exp 6, busy=%b exp 0", idx, busy);
        end
        checks++;
        if (!full_seen) begin
            errors++;
            $display("FAIL b2b_full ready_low_seen got 0 exp 1");
        end
    endtask

    task automatic test_enable();
        int n;
        enable = 1'b0;
        in = 8'h30;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        repeat (2 * DIV) begin
            tick();
            checks++;
            if ({out, ready, busy, fifo_count} !== m_vec()) begin
                errors++;
                $display("FAIL en_hold_line t=%0t got %b exp %b", $time, {out, ready, busy, fifo_count}, m_vec());
            end
        end
        checks++;
        if ({out, busy, fifo_count} !== {1'b1, 1'b1, 3'd1}) begin
            errors++;
            $display("FAIL en_hold got %b exp %b", {out, busy, fifo_count}, 5'b11001);
        end
        enable = 1'b1;
        tick();
        checks++;
        if (out !== 1'b0) begin
            errors++;
            $display("FAIL en_start got out=%b exp 0", out);
        end
        in = 8'($urandom);
        valid = 1'b1;
        tick();
        valid = 1'b0;
        repeat (FRAME / 2) tick();
        enable = 1'b0;
        repeat (FRAME + 2 * DIV) begin
            tick();
            checks++;
            if ({out, ready, busy, fifo_count} !== m_vec()) begin
                errors++;
                $display("FAIL en_mid_line t=%0t got %b exp %b", $time, {out, ready, busy, fifo_count}, m_vec());
            end
        end
        checks++;
        if ({out, busy, fifo_count} !== {1'b1, 1'b1, 3'd1}) begin
            errors++;
            $display("FAIL en_mid_wait got %b exp %b", {out, busy, fifo_count}, 5'b11001);
        end
        enable = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 2 * FRAME) begin
            tick();
            n++;
            checks++;
            if ({out, ready, busy, fifo_count} !== m_vec()) begin
                errors++;
                $display("FAIL en_drain_line t=%0t got %b exp %b", $time, {out, ready, busy, fifo_count}, m_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        enable = 1'b1;
        valid = 1'b1;
        in = 8'($urandom);
        tick();
        in = 8'($urandom);
        tick();
        in = 8'($urandom);
        tick();
        valid = 1'b0;
        repeat (FRAME / 2) tick();
        reset = 1'b1;
        #1;
        checks++;
        if ({out, ready, busy, fifo_count} !== {1'b1, 1'b1, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL reset_async got %b exp %b", {out, ready, busy, fifo_count}, 6'b110000);
        end
        tick();
        reset = 1'b0;
        repeat (2 * FRAME) begin
            tick();
            checks++;
            if ({out, ready, busy, fifo_count} !== m_vec()) begin
                errors++;
                $display("FAIL reset_resume t=%0t got %b exp %b", $time, {out, ready, busy, fifo_count}, m_vec());
            end
        end
    endtask

    task automatic test_random();
        int n;
        for (int c = 0; c < 4000; c++) begin
            valid = $urandom_range(0, 5) == 0;
            in = 8'($urandom);
            if ($urandom_range(0, 99) == 0) enable = ~enable;
            tick();
            checks++;
            if ({out, ready, busy, fifo_count} !== m_vec()) begin
                errors++;
                $display("FAIL random_line t=%0t got %b exp %b", $time, {out, ready, busy, fifo_count}, m_vec());
            end
        end
        valid = 1'b0;
        enable = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < (DEPTH + 1) * (FRAME + 2)) begin
            tick();
            n++;
            checks++;
            if ({out, ready, busy, fifo_count} !== m_vec()) begin
                errors++;
                $display("FAIL random_drain t=%0t got %b exp %b", $time, {out, ready, busy, fifo_count}, m_vec());
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL random_timeout busy got %b exp 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_single(8'h55);
        test_single(8'hA5);
        test_single(8'h07);
        test_single(8'hFF);
        test_back_to_back();
        test_enable();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
